// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding,
// host command bytes and the per-state byte-ready decode.
package inst_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CNT_LO = 3'd1;
    localparam state_t ST_CNT_HI = 3'd2;
    localparam state_t ST_WORD   = 3'd3;
    localparam state_t ST_WRITE  = 3'd4;
    localparam state_t ST_CHK    = 3'd5;
    localparam state_t ST_DONE   = 3'd6;
    localparam state_t ST_RUN    = 3'd7;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'h03;
    localparam logic [7:0] CMD_STOP = 8'h04;

    // Bytes are refused only while a word is being written or a load is closing.
    function automatic logic rx_ready_for(input state_t st);
        return (st != ST_WRITE) && (st != ST_DONE);
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream, halt and instruction-memory/fetch-control signals of the loader.
// master: host/pipeline side, slave: the loader itself.
interface inst_loader_if #(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned BYTE_W = 8
);
    logic [BYTE_W-1:0] i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic              i_halt;
    logic              o_inst_mem_wr_en;
    logic [NBITS-1:0]  o_inst_mem_addr;
    logic [NBITS-1:0]  o_inst_mem_data;
    logic              o_step;
    logic              o_running;
    logic              o_load_done;
    logic              o_err;

    modport master (
        output i_rx_data, i_rx_valid, i_halt,
        input  o_rx_ready, o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data,
        input  o_step, o_running, o_load_done, o_err
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_halt,
        output o_rx_ready, o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data,
        output o_step, o_running, o_load_done, o_err
    );

endinterface

// File: rtl/inst_loader_word_assembler.sv
// Little-endian word assembler: collects BYTE_W-wide bytes into an NBITS word,
// first byte in the least-significant lane. o_word/o_word_done are valid in the
// cycle the last byte of a word is presented with i_en.
module inst_loader_word_assembler #(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [NBITS-1:0]  o_word,
    output logic              o_word_done
);

    localparam int unsigned NBYTES = NBITS / BYTE_W;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [IDX_W-1:0]        idx_q;
    // Holds the bytes already received; the incoming byte completes the top lane.
    logic [NBITS-BYTE_W-1:0] shift_q;

    assign o_word      = {i_byte, shift_q};
    assign o_word_done = i_en && (idx_q == IDX_W'(NBYTES - 1));

    // Byte index and shift register advance on every accepted data byte
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else if (i_clear) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else if (i_en) begin
            shift_q <= o_word[NBITS-1:BYTE_W];
            idx_q   <= o_word_done ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: decodes host command bytes, loads N little-endian words into
// instruction memory at byte addresses 0, 4, 8, ... and drives the fetch step/run
// enables. Optional INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    inst_loader_if.slave bus
);

    localparam int unsigned CNT_W = 2 * BYTE_W;

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_LOAD = ST_CHK;
`else
    localparam state_t ST_AFTER_LOAD = ST_DONE;
`endif

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic [BYTE_W-1:0] cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic [CNT_W-1:0]  count_next;

    logic              rx_ready_q;
    logic              step_q;
    logic              running_q;
    logic              wr_en_q;
    logic              load_done_q;
    logic [NBITS-1:0]  addr_q;
    logic [NBITS-1:0]  data_q;

    logic              accept;
    logic              asm_en;
    logic              load_start;
    logic              step_pulse;
    logic [NBITS-1:0]  word;
    logic              word_done;

    assign accept = bus.i_rx_valid && rx_ready_q;
    assign asm_en = accept && (state_q == ST_WORD);

    inst_loader_word_assembler #(
        .NBITS (NBITS),
        .BYTE_W(BYTE_W)
    ) u_word_assembler (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (load_start),
        .i_en       (asm_en),
        .i_byte     (bus.i_rx_data),
        .o_word     (word),
        .o_word_done(word_done)
    );

`ifdef INST_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_q;

    // Running XOR of every data byte of the current load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chk_q <= '0;
        end else if (load_start) begin
            chk_q <= '0;
        end else if (asm_en) begin
            chk_q <= chk_q ^ bus.i_rx_data;
        end
    end
`endif

    // Command decode, load sequencing and run/halt control
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        cnt_lo_d   = cnt_lo_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        step_pulse = 1'b0;
        load_start = 1'b0;
        count_next = {bus.i_rx_data, cnt_lo_q};

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.i_rx_data)
                        CMD_LOAD: begin
                            state_d    = ST_CNT_LO;
                            err_d      = 1'b0;
                            load_start = 1'b1;
                        end
                        CMD_STEP: step_pulse = 1'b1;
                        // A RUN while already halted would only re-halt; drop it.
                        CMD_RUN: if (!bus.i_halt) state_d = ST_RUN;
                        CMD_STOP: begin
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end

            ST_CNT_LO: begin
                if (accept) begin
                    cnt_lo_d = bus.i_rx_data;
                    state_d  = ST_CNT_HI;
                end
            end

            ST_CNT_HI: begin
                if (accept) begin
                    count_d    = count_next;
                    word_idx_d = '0;
                    if (count_next == '0) begin
                        state_d = ST_AFTER_LOAD;
                    end else if (32'(count_next) > MEM_DEPTH) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WORD;
                    end
                end
            end

            ST_WORD: begin
                if (word_done) state_d = ST_WRITE;
            end

            ST_WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                if (word_idx_q == count_q - CNT_W'(1)) state_d = ST_AFTER_LOAD;
                else                                   state_d = ST_WORD;
            end

`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if (bus.i_rx_data == chk_q) begin
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif

            ST_DONE: state_d = ST_IDLE;

            ST_RUN: begin
                // Halt and STOP share one exit; other bytes are swallowed.
                if (bus.i_halt || (accept && (bus.i_rx_data == CMD_STOP))) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, load bookkeeping and registered outputs (decoded from next state)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            cnt_lo_q    <= '0;
            count_q     <= '0;
            word_idx_q  <= '0;
            rx_ready_q  <= 1'b0;
            step_q      <= 1'b0;
            running_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            load_done_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            cnt_lo_q    <= cnt_lo_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            rx_ready_q  <= rx_ready_for(state_d);
            step_q      <= step_pulse || (state_d == ST_RUN);
            running_q   <= (state_d == ST_RUN);
            wr_en_q     <= (state_d == ST_WRITE);
            load_done_q <= (state_d == ST_DONE);
            if (word_done) begin
                addr_q <= NBITS'({word_idx_q, 2'b00});
                data_q <= word;
            end
        end
    end

    assign bus.o_rx_ready       = rx_ready_q;
    assign bus.o_step           = step_q;
    assign bus.o_running        = running_q;
    assign bus.o_inst_mem_wr_en = wr_en_q;
    assign bus.o_inst_mem_addr  = addr_q;
    assign bus.o_inst_mem_data  = data_q;
    assign bus.o_load_done      = load_done_q;
    assign bus.o_err            = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed byte streams, expected memory
// writes queued by the stimulus and checked by an independent monitor.
module tb_inst_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    inst_loader_if #(.NBITS(32), .BYTE_W(8)) bus ();

    inst_loader #(
        .NBITS    (32),
        .BYTE_W   (8),
        .MEM_DEPTH(256)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    int   wr_count    = 0;
    int   done_count  = 0;
    int   step_cycles = 0;
    int   step_rises  = 0;
    int   run_cycles  = 0;
    logic prev_wr     = 1'b0;
    logic prev_step   = 1'b0;
    logic [7:0] tb_chk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes, counts pulses on the step/run/done outputs
    always @(negedge clk) begin
        if (rst) begin
            prev_wr   = 1'b0;
            prev_step = 1'b0;
        end else begin
            if (bus.o_inst_mem_wr_en) begin
                wr_count++;
                check("wr_rx_ready_low", 32'(bus.o_rx_ready), 32'd0);
                check("wr_single_cycle", 32'(prev_wr), 32'd0);
                check("wr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check("wr_addr", bus.o_inst_mem_addr, exp_addr_q.pop_front());
                    check("wr_data", bus.o_inst_mem_data, exp_data_q.pop_front());
                end
            end
            if (bus.o_load_done) done_count++;
            if (bus.o_step) step_cycles++;
            if (bus.o_step && !prev_step) step_rises++;
            if (bus.o_running) run_cycles++;
            prev_wr   = bus.o_inst_mem_wr_en;
            prev_step = bus.o_step;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        while (!bus.o_rx_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("rx_ready_timeout", 32'(bus.o_rx_ready), 32'd1);
        else         tick();
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            tb_chk = tb_chk ^ b;
            send_byte(b);
        end
    endtask

    task automatic finish_load();
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(tb_chk);
`endif
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wr, b_done, b_step, b_rise, b_run;

        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_halt     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(bus.o_rx_ready), 32'd0);
        check("rst_wr_en", 32'(bus.o_inst_mem_wr_en), 32'd0);
        check("rst_step", 32'(bus.o_step), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_rx_ready", 32'(bus.o_rx_ready), 32'd1);
        check("post_rst_running", 32'(bus.o_running), 32'd0);

        // 1: LOAD two words
        tb_chk = 8'h00;
        b_wr = wr_count; b_done = done_count;
        expect_write(32'h0, 32'h12345678);
        expect_write(32'h4, 32'hDEADBEEF);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        finish_load();
        repeat (4) tick();
        check("t1_writes", 32'(wr_count - b_wr), 32'd2);
        check("t1_done_pulses", 32'(done_count - b_done), 32'd1);
        check("t1_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        check("t1_err", 32'(bus.o_err), 32'd0);

        // 2: single STEP, then three separated STEPs
        b_step = step_cycles; b_rise = step_rises;
        send_byte(8'h02);
        repeat (3) tick();
        check("t2_step_cycles", 32'(step_cycles - b_step), 32'd1);
        b_step = step_cycles; b_rise = step_rises;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h02);
            tick();
        end
        repeat (3) tick();
        check("t2_step3_cycles", 32'(step_cycles - b_step), 32'd3);
        check("t2_step3_pulses", 32'(step_rises - b_rise), 32'd3);
        check("t2_running", 32'(bus.o_running), 32'd0);

        // 3: RUN, halt sampled on the 10th edge after acceptance
        b_step = step_cycles; b_run = run_cycles;
        send_byte(8'h03);
        repeat (9) @(posedge clk);
        #1;
        bus.i_halt = 1'b1;
        tick();
        check("t3_step_dropped", 32'(bus.o_step), 32'd0);
        check("t3_running_dropped", 32'(bus.o_running), 32'd0);
        repeat (2) tick();
        check("t3_step_cycles", 32'(step_cycles - b_step), 32'd10);
        check("t3_run_cycles", 32'(run_cycles - b_run), 32'd10);
        b_step = step_cycles; b_run = run_cycles;
        send_byte(8'h03);
        repeat (3) tick();
        check("t3_halted_no_step", 32'(step_cycles - b_step), 32'd0);
        check("t3_halted_no_run", 32'(run_cycles - b_run), 32'd0);
        check("t3_halted_no_err", 32'(bus.o_err), 32'd0);
        bus.i_halt = 1'b0;
        // RUN ended by STOP; a stray byte in RUN is discarded
        send_byte(8'h03);
        send_byte(8'h55);
        check("t3_run_active", 32'(bus.o_running), 32'd1);
        send_byte(8'h04);
        check("t3_stop_exit", 32'(bus.o_running), 32'd0);
        check("t3_stop_no_err", 32'(bus.o_err), 32'd0);

        // 4: count and command errors
        b_wr = wr_count; b_done = done_count;
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h01);
        repeat (2) tick();
        check("t4_count_err", 32'(bus.o_err), 32'd1);
        check("t4_no_writes", 32'(wr_count - b_wr), 32'd0);
        check("t4_no_done", 32'(done_count - b_done), 32'd0);
        check("t4_idle_ready", 32'(bus.o_rx_ready), 32'd1);
        tb_chk = 8'h00;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        finish_load();
        repeat (3) tick();
        check("t4_n0_err_clear", 32'(bus.o_err), 32'd0);
        check("t4_n0_done", 32'(done_count - b_done), 32'd1);
        send_byte(8'h7F);
        tick();
        check("t4_bad_cmd_err", 32'(bus.o_err), 32'd1);
        send_byte(8'h01);
        tick();
        check("t4_load_clears_err", 32'(bus.o_err), 32'd0);
        tb_chk = 8'h00;
        send_byte(8'h00); send_byte(8'h00);
        finish_load();
        repeat (3) tick();
        check("t4_n0_done2", 32'(done_count - b_done), 32'd2);

        // 5: reset in the middle of a word
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_rx_ready", 32'(bus.o_rx_ready), 32'd0);
        check("t5_rst_addr", bus.o_inst_mem_addr, 32'd0);
        check("t5_rst_data", bus.o_inst_mem_data, 32'd0);
        check("t5_rst_done", 32'(bus.o_load_done), 32'd0);
        check("t5_rst_running", 32'(bus.o_running), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t5_ready_after_rst", 32'(bus.o_rx_ready), 32'd1);
        b_wr = wr_count; b_done = done_count;
        tb_chk = 8'h00;
        expect_write(32'h0, 32'h44332211);
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        send_word(32'h44332211);
        finish_load();
        repeat (4) tick();
        check("t5_writes", 32'(wr_count - b_wr), 32'd1);
        check("t5_done", 32'(done_count - b_done), 32'd1);
        check("t5_queue_empty", 32'(exp_addr_q.size()), 32'd0);

`ifdef INST_LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch
        b_done = done_count;
        expect_write(32'h0, 32'h08040201);
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0F);
        repeat (3) tick();
        check("t6_chk_ok_done", 32'(done_count - b_done), 32'd1);
        check("t6_chk_ok_err", 32'(bus.o_err), 32'd0);
        b_done = done_count;
        expect_write(32'h0, 32'h08040201);
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0E);
        repeat (3) tick();
        check("t6_chk_bad_no_done", 32'(done_count - b_done), 32'd0);
        check("t6_chk_bad_err", 32'(bus.o_err), 32'd1);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Host-side front end that feeds the instruction-fetch stage: consumes a byte stream from the UART receiver, loads instruction words into instruction memory and generates the step/run enable for the pipeline.
- Drives instruction-memory write enable, write address and write data, plus the step input of the fetch stage and its cycle counter.
- Command-driven FSM with a valid/ready byte handshake, little-endian word assembly and a halt-aware run mode.

Parameters:
NBITS, 32, instruction/address width
BYTE_W, 8, received byte width
MEM_DEPTH, 256, instruction memory capacity in words; larger load counts are rejected

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_rx_data  in  8  received byte
i_rx_valid  in  1  byte available
o_rx_ready  out  1  loader can accept a byte
i_halt  in  1  pipeline reached halt instruction (level)
o_inst_mem_wr_en  out  1  instruction memory write strobe
o_inst_mem_addr  out  NBITS  byte write address
o_inst_mem_data  out  NBITS  write data
o_step  out  1  pipeline advance enable
o_running  out  1  RUN mode active
o_load_done  out  1  one-cycle pulse when a load completes
o_err  out  1  sticky protocol error

Behaviour:
- Reset, asynchronous, active-high:
  - State becomes IDLE.
  - All outputs are 0, except o_rx_ready, which is 1 once reset deasserts.
  - Partial word, word index and count are discarded.
  - Memory contents are untouched.
- Handshake: a byte is accepted when i_rx_valid and o_rx_ready are both 1 on a rising edge. o_rx_ready is 1 in IDLE, CNT_LO, CNT_HI, WORD and RUN; it is 0 in WRITE and DONE. All outputs are registered.
- IDLE, on an accepted byte:
  - 0x01 LOAD → CNT_LO; clears o_err.
  - 0x02 STEP → o_step = 1 for exactly one cycle, starting the cycle after acceptance; stays in IDLE.
  - 0x03 RUN → RUN, provided i_halt = 0. If i_halt = 1 the byte is ignored: no step, no error.
  - 0x04 STOP is ignored in IDLE.
  - Any other value sets o_err; stays in IDLE.
- CNT_LO / CNT_HI: receive a 16-bit word count N, low byte first.
  - N = 0 → DONE.
  - N > MEM_DEPTH → set o_err, go to IDLE.
  - Otherwise → WORD, with word index = 0 and byte index = 0.
- WORD: accept 4 bytes, little-endian (the first byte lands in bits 7:0). The 4th accepted byte → WRITE.
- WRITE: held for one cycle.
  - o_inst_mem_wr_en = 1, o_inst_mem_addr = word_index × 4, o_inst_mem_data = assembled word.
  - Word index increments. If word index = N−1 → DONE; else → WORD.
- DONE: o_load_done = 1 for one cycle → IDLE.
- RUN: o_step = 1 and o_running = 1 continuously, starting the cycle after the RUN byte is accepted.
  - i_halt sampled 1, or an accepted 0x04 → IDLE, with o_step = 0 and o_running = 0 from the next cycle.
  - Both conditions in the same cycle → the same single exit.
  - Other bytes received in RUN are accepted and discarded.
- o_step is never asserted during LOAD states, so fetch and load never overlap.
- Reset mid-load: words already written remain in memory; the next LOAD restarts at address 0.
- Word index wrap cannot occur because N ≤ MEM_DEPTH.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - After the N words, one extra CHK byte is expected (state CHK, o_rx_ready = 1).
  - CHK must equal the XOR of all 4N data bytes.
  - Match → DONE.
  - Mismatch → o_err = 1 and IDLE, with no o_load_done pulse.
  - With N = 0 the checksum expected is 0x00.
- Undefined: no CHK state. The last WRITE goes straight to DONE.

Decomposition:
- Shared package (inst_loader_pkg):
  - State encoding: IDLE, CNT_LO, CNT_HI, WORD, WRITE, CHK, DONE, RUN.
  - Command constants: CMD_LOAD = 0x01, CMD_STEP = 0x02, CMD_RUN = 0x03, CMD_STOP = 0x04.
- One natural sub-module, word_assembler: a byte-index counter plus a shift register that emits a word-complete flag.
- The FSM, address counter and step logic stay in inst_loader.

Test Plan:
1. LOAD, N = 2, bytes 78 56 34 12, EF BE AD DE:
   - Writes 0x12345678 @0x0 and 0xDEADBEEF @0x4, each with a single-cycle wr_en.
   - o_load_done pulses once.
   - o_rx_ready = 0 during each WRITE.
2. STEP:
   - o_step is high for exactly 1 cycle.
   - Three consecutive STEP bytes give 3 separate pulses.
3. RUN, then i_halt asserted 10 cycles later:
   - o_step/o_running are high for 10 cycles and drop 1 cycle after halt.
   - RUN with i_halt already 1 → no o_step.
4. Count and command errors:
   - LOAD with N = 0x0101 (257) → o_err = 1, IDLE, no writes.
   - Unknown byte 0x7F → o_err = 1.
   - A subsequent LOAD clears o_err.
5. i_rst asserted after 2 bytes of a word:
   - Outputs are 0 immediately, asynchronously.
   - A new LOAD with N = 1 writes @0x0 with only the new bytes.
6. With INST_LOADER_CHECKSUM_EN defined, LOAD N = 1, bytes 01 02 04 08:
   - CHK 0x0F → o_load_done pulses.
   - CHK 0x0E → o_err = 1, no o_load_done pulse.
